// File: rtl/wb_regfile_pkg.sv
// Shared pipeline definitions for the write-back stage and the MEM/WB register.
// Widths, the hardwired-zero register index and the 2-bit WB control field.
package wb_regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int REG_ZERO = 0;

    // WB control field as carried in MEM/WB: bit1 = reg_write, bit0 = mem_to_reg.
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

endpackage : wb_regfile_pkg

// File: rtl/regfile_core.sv
// Architectural register storage: async-reset clear, one write port and two
// combinational read ports. Index REG_ZERO is never written and always reads 0.
module regfile_core
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    always_comb begin
        // NOTE: start from the held value so every path assigns regs_d; no latch.
        regs_d = regs_q;
        if (we && (waddr != ZERO_IDX)) begin
            regs_d[waddr] = wdata;
        end
    end

    // NOTE: the array is cleared by reset because software may read any register
    // before writing it; the clear is asynchronous like every other flop here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking so all flops update from pre-edge values.
            regs_q <= regs_d;
        end
    end

    assign ra_data = (ra_addr == ZERO_IDX) ? '0 : regs_q[ra_addr];
    assign rb_data = (rb_addr == ZERO_IDX) ? '0 : regs_q[rb_addr];

endmodule : regfile_core

// File: rtl/wb_regfile.sv
// Write-back stage: result mux, register file commit, optional write-through
// bypass (WB_REGFILE_BYPASS_EN) and a 32-bit committed-write counter.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_reg_write,
    input  logic              wb_mem_to_reg,
    input  logic [DATA_W-1:0] wb_mem_data,
    input  logic [DATA_W-1:0] wb_alu_result,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data,
    output logic [31:0]       wb_count
);

    wb_ctrl_t          ctrl;
    logic              commit;
    logic [DATA_W-1:0] rs_core;
    logic [DATA_W-1:0] rt_core;
    logic [31:0]       wb_count_q;
    logic [31:0]       wb_count_d;

    assign ctrl    = '{reg_write: wb_reg_write, mem_to_reg: wb_mem_to_reg};
    assign wb_data = ctrl.mem_to_reg ? wb_mem_data : wb_alu_result;
    assign commit  = ctrl.reg_write && (wb_rd != ADDR_W'(REG_ZERO));

    regfile_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (commit),
        .waddr   (wb_rd),
        .wdata   (wb_data),
        .ra_addr (rs_addr),
        .rb_addr (rt_addr),
        .ra_data (rs_core),
        .rb_data (rt_core)
    );

`ifdef WB_REGFILE_BYPASS_EN
    // commit already excludes the zero register, so r0 is never bypassed.
    assign rs_data = (commit && (rs_addr == wb_rd)) ? wb_data : rs_core;
    assign rt_data = (commit && (rt_addr == wb_rd)) ? wb_data : rt_core;
`else
    assign rs_data = rs_core;
    assign rt_data = rt_core;
`endif

    // Wraps naturally at 2^32.
    always_comb begin
        wb_count_d = wb_count_q + 32'(commit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_count_q <= '0;
        end else begin
            wb_count_q <= wb_count_d;
        end
    end

    assign wb_count = wb_count_q;

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile against an array-based architectural model.
// Define WB_REGFILE_BYPASS_EN for both RTL and bench to test the bypass build.
module tb_wb_regfile;

    logic        clk;
    logic        rst_n;
    logic        wb_reg_write;
    logic        wb_mem_to_reg;
    logic [31:0] wb_mem_data;
    logic [31:0] wb_alu_result;
    logic [4:0]  wb_rd;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] wb_data;
    logic [31:0] wb_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_regs [32];
    logic [31:0] model_count;

    wb_regfile dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb_reg_write  (wb_reg_write),
        .wb_mem_to_reg (wb_mem_to_reg),
        .wb_mem_data   (wb_mem_data),
        .wb_alu_result (wb_alu_result),
        .wb_rd         (wb_rd),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .wb_data       (wb_data),
        .wb_count      (wb_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] exp_wb();
        return wb_mem_to_reg ? wb_mem_data : wb_alu_result;
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] addr);
        if (addr == 5'd0) return 32'h0;
`ifdef WB_REGFILE_BYPASS_EN
        if (wb_reg_write && wb_rd != 5'd0 && addr == wb_rd) return exp_wb();
`endif
        return model_regs[addr];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
        model_count = 32'h0;
    endtask

    task automatic model_commit();
        if (wb_reg_write === 1'b1 && wb_rd != 5'd0) begin
            model_regs[wb_rd] = exp_wb();
            model_count       = model_count + 32'd1;
        end
    endtask

    task automatic drive(input logic we, input logic m2r, input logic [31:0] mem,
                         input logic [31:0] alu, input logic [4:0] rd,
                         input logic [4:0] rs, input logic [4:0] rt);
        wb_reg_write  = we;
        wb_mem_to_reg = m2r;
        wb_mem_data   = mem;
        wb_alu_result = alu;
        wb_rd         = rd;
        rs_addr       = rs;
        rt_addr       = rt;
    endtask

    // Clock edge with the current inputs, then back to the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_commit();
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd31);
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (rs_data !== 32'h0 || rt_data !== 32'h0 || wb_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: rs=%h rt=%h count=%h, required 0/0/0", rs_data, rt_data, wb_count);
        end
        @(negedge clk);
        rst_n = 1'b1;

        drive(1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF, 5'd5, 5'd5, 5'd5);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5);
        #1;
        checks++;
        if (rs_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL reset_prewrite: r5=%h, required deadbeef", rs_data);
        end

        // Mid-cycle reset with a commit pending: state clears with no clock edge.
        drive(1'b1, 1'b1, 32'h5555_AAAA, 32'h1, 5'd5, 5'd5, 5'd5);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rs_data !== 32'h0 || rt_data !== 32'h0 || wb_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_async: rs=%h rt=%h count=%h, required 0/0/0", rs_data, rt_data, wb_count);
        end
        checks++;
        if (wb_data !== 32'h5555_AAAA) begin
            errors++;
            $display("FAIL reset_wb_data: wb_data=%h, required 5555aaaa", wb_data);
        end
        model_clear();
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0);
        rst_n = 1'b1;
        #1;
        checks++;
        if (rs_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_lost_commit: r5=%h, required 0", rs_data);
        end
    endtask

    task automatic test_alu_write();
        drive(1'b1, 1'b0, $urandom, 32'h0000_1234, 5'd7, 5'd0, 5'd0);
        #1;
        checks++;
        if (wb_data !== 32'h0000_1234) begin
            errors++;
            $display("FAIL alu_wb_data: wb_data=%h, required 00001234", wb_data);
        end
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd0);
        #1;
        checks++;
        if (rs_data !== 32'h0000_1234 || wb_count !== 32'd1) begin
            errors++;
            $display("FAIL alu_write: rs=%h count=%0d, required 00001234/1", rs_data, wb_count);
        end
    endtask

    task automatic test_mem_write();
        drive(1'b1, 1'b1, 32'hCAFE_F00D, 32'h1, 5'd31, 5'd0, 5'd0);
        #1;
        checks++;
        if (wb_data !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL mem_wb_data: wb_data=%h, required cafef00d", wb_data);
        end
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd31, 5'd31);
        #1;
        checks++;
        if (rs_data !== 32'hCAFE_F00D || rt_data !== 32'hCAFE_F00D || wb_count !== 32'd2) begin
            errors++;
            $display("FAIL mem_write: rs=%h rt=%h count=%0d, required cafef00d/cafef00d/2",
                     rs_data, rt_data, wb_count);
        end
    endtask

    task automatic test_zero_reg();
        logic [31:0] cnt_before;
        cnt_before = wb_count;
        drive(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
        #1;
        checks++;
        if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
            errors++;
            $display("FAIL zero_bypass: rs=%h rt=%h, required 0/0", rs_data, rt_data);
        end
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        #1;
        checks++;
        if (rs_data !== 32'h0 || wb_count !== 32'd2) begin
            errors++;
            $display("FAIL zero_write: r0=%h count=%0d (was %0d), required 0/2", rs_data, wb_count, cnt_before);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] exp_now;
`ifdef WB_REGFILE_BYPASS_EN
        exp_now = 32'h22;
`else
        exp_now = 32'h11;
`endif
        drive(1'b1, 1'b0, 32'h0, 32'h11, 5'd9, 5'd0, 5'd0);
        tick();
        drive(1'b1, 1'b0, 32'h0, 32'h22, 5'd9, 5'd9, 5'd9);
        #1;
        checks++;
        if (rs_data !== exp_now || rt_data !== exp_now) begin
            errors++;
            $display("FAIL same_cycle: rs=%h rt=%h, required %h", rs_data, rt_data, exp_now);
        end
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd9);
        #1;
        checks++;
        if (rs_data !== 32'h22 || rt_data !== 32'h22) begin
            errors++;
            $display("FAIL same_cycle_next: rs=%h rt=%h, required 22", rs_data, rt_data);
        end
    endtask

    task automatic test_counter_wrap();
        force dut.wb_count_q = 32'hFFFF_FFFF;
        drive(1'b1, 1'b0, 32'h0, 32'h5, 5'd3, 5'd0, 5'd0);
        #1;
        checks++;
        if (wb_count !== 32'hFFFF_FFFF || dut.wb_count_d !== 32'h0) begin
            errors++;
            $display("FAIL counter_wrap: count=%h next=%h, required ffffffff/00000000",
                     wb_count, dut.wb_count_d);
        end
        rst_n = 1'b0;
        release dut.wb_count_q;
        #1;
        checks++;
        if (wb_count !== 32'h0) begin
            errors++;
            $display("FAIL counter_reset: count=%h, required 0", wb_count);
        end
        model_clear();
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] e_wb;
        logic [31:0] e_rs;
        logic [31:0] e_rt;
        for (int n = 0; n < 400; n++) begin
            // Small address pool so reads frequently hit recent writes.
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  (n % 4 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)));
            #1;
            e_wb = exp_wb();
            e_rs = exp_read(rs_addr);
            e_rt = exp_read(rt_addr);
            checks++;
            if (wb_data !== e_wb || rs_data !== e_rs || rt_data !== e_rt || wb_count !== model_count) begin
                errors++;
                $display("FAIL random[%0d]: wb=%h rs=%h rt=%h cnt=%0d, required %h %h %h %0d",
                         n, wb_data, rs_data, rt_data, wb_count, e_wb, e_rs, e_rt, model_count);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_mem_write();
        test_zero_reg();
        test_same_cycle();
        test_counter_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_wb_regfile
